rvv_alu_seq_ctrl: RTL and testbench

Sequencer placed in front of the vector ALU wrapper. It buffers decoded vector-arithmetic instructions from the core in a small FIFO and issues them to the wrapper one at a time. For each instruction it drives the run handshake and holds the configuration fields stable until the wrapper reports done. It then returns a completion response (normal, illegal or timed-out) to the core.

---
 rtl/rvv_alu_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_rvv_alu_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_alu_seq_ctrl.sv
// Vector ALU sequencer: buffers decoded instructions, runs them one at a time on the wrapper,
// and returns in-order completions. Optional watchdog enabled by RVV_ALU_SEQ_WATCHDOG_EN.
module rvv_alu_seq_ctrl #(
    parameter int NB_LANES    = 1,
    parameter int QDEPTH_LOG2 = 1,
    parameter int TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [5:0]  issue_opcode,
    input  logic        issue_mask,
    input  logic [4:0]  issue_vs1_index,
    input  logic [2:0]  issue_vsew,
    input  logic [2:0]  issue_op_type,
    input  logic [16:0] issue_vl,
    output logic [5:0]  alu_opcode,
    output logic        alu_instr_mask,
    output logic [4:0]  alu_vs1_index,
    output logic [2:0]  alu_vsew,
    output logic [2:0]  alu_op_type,
    output logic [16:0] alu_vl,
    output logic [16:0] alu_arith_remaining,
    output logic        alu_run,
    input  logic        alu_done,
    input  logic        alu_instr_valid,
    output logic        cmpl_valid,
    input  logic        cmpl_ready,
    output logic        cmpl_illegal,
    output logic        cmpl_timeout,
    output logic [5:0]  cmpl_opcode,
    output logic        busy
);
    typedef struct packed {
        logic [5:0]  opcode;
        logic        mask;
        logic [4:0]  vs1;
        logic [2:0]  vsew;
        logic [2:0]  op_type;
        logic [16:0] vl;
    } req_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    localparam int                   DEPTH   = 1 << QDEPTH_LOG2;
    localparam logic [QDEPTH_LOG2:0] DEPTH_C = (QDEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [QDEPTH_LOG2:0] CNT_ONE = (QDEPTH_LOG2 + 1)'(1);
    localparam logic [QDEPTH_LOG2-1:0] PTR_ONE = QDEPTH_LOG2'(1);
    localparam logic [16:0]          LANES   = 17'(1 << NB_LANES);

    req_t                   fifo_q [DEPTH];
    req_t                   issue_req, head, cfg_q;
    logic [QDEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic [QDEPTH_LOG2:0]   count;
    logic                   full, empty, push, pop;
    state_t                 state_q, state_d;
    logic [16:0]            remaining_q;
    logic                   first_q, ill_q, ill_set;

    assign issue_req = {issue_opcode, issue_mask, issue_vs1_index, issue_vsew, issue_op_type, issue_vl};
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign push      = issue_valid && !full;
    assign pop       = (state_q == IDLE) && !empty;
    assign head      = fifo_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= issue_req;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
        end
    end

`ifdef RVV_ALU_SEQ_WATCHDOG_EN
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);
    logic [9:0] wd_q;
    logic       to_q, to_set;
`endif

    always_comb begin
        state_d = state_q;
        ill_set = 1'b0;
`ifdef RVV_ALU_SEQ_WATCHDOG_EN
        to_set  = 1'b0;
`endif
        case (state_q)
            IDLE: if (!empty) state_d = LOAD;
            LOAD: state_d = (cfg_q.vl == '0) ? RESP : RUN;
            RUN: begin
                // illegal is only judged on the first RUN cycle; done beats the watchdog
                if (first_q && !alu_instr_valid) begin
                    state_d = RESP;
                    ill_set = 1'b1;
                end else if (alu_done) begin
                    state_d = RESP;
                end
`ifdef RVV_ALU_SEQ_WATCHDOG_EN
                else if (wd_q == WD_LAST) begin
                    state_d = RESP;
                    to_set  = 1'b1;
                end
`endif
            end
            RESP: if (cmpl_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_q == LOAD);
            if (pop) begin
                cfg_q       <= head;
                remaining_q <= (head.vl < LANES) ? head.vl : LANES;
            end
            if (state_q == IDLE) ill_q <= 1'b0;
            else if (ill_set)    ill_q <= 1'b1;
        end
    end

`ifdef RVV_ALU_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= (state_q == RUN) ? wd_q + 10'd1 : '0;
            if (state_q == IDLE) to_q <= 1'b0;
            else if (to_set)     to_q <= 1'b1;
        end
    end
    assign cmpl_timeout = cmpl_valid && to_q;
`else
    assign cmpl_timeout = 1'b0;
`endif

    assign issue_ready         = !full;
    assign alu_opcode          = cfg_q.opcode;
    assign alu_instr_mask      = cfg_q.mask;
    assign alu_vs1_index       = cfg_q.vs1;
    assign alu_vsew            = cfg_q.vsew;
    assign alu_op_type         = cfg_q.op_type;
    assign alu_vl              = cfg_q.vl;
    assign alu_arith_remaining = remaining_q;
    assign alu_run             = (state_q == RUN);
    assign cmpl_valid          = (state_q == RESP);
    assign cmpl_illegal        = cmpl_valid && ill_q;
    assign cmpl_opcode         = cfg_q.opcode;
    assign busy                = !empty || (state_q != IDLE);
endmodule

// File: tb/tb_rvv_alu_seq_ctrl.sv
// Random + directed bench for rvv_alu_seq_ctrl against an instruction-level outcome model.
module tb_rvv_alu_seq_ctrl;
    localparam int NBL   = 2;
    localparam int QD    = 1;
    localparam int TO    = 15;
    localparam int LANES = 1 << NBL;
    localparam int N     = 128;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        issue_valid = 1'b0, issue_ready;
    logic [5:0]  issue_opcode = '0;
    logic        issue_mask = 1'b0;
    logic [4:0]  issue_vs1_index = '0;
    logic [2:0]  issue_vsew = '0, issue_op_type = '0;
    logic [16:0] issue_vl = '0;
    logic [5:0]  alu_opcode, cmpl_opcode;
    logic        alu_instr_mask, alu_run, cmpl_valid, cmpl_illegal, cmpl_timeout, busy;
    logic [4:0]  alu_vs1_index;
    logic [2:0]  alu_vsew, alu_op_type;
    logic [16:0] alu_vl, alu_arith_remaining;
    logic        alu_done = 1'b0, alu_instr_valid = 1'b1, cmpl_ready = 1'b0;

    rvv_alu_seq_ctrl #(.NB_LANES(NBL), .QDEPTH_LOG2(QD), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_mask(issue_mask), .issue_vs1_index(issue_vs1_index),
        .issue_vsew(issue_vsew), .issue_op_type(issue_op_type), .issue_vl(issue_vl),
        .alu_opcode(alu_opcode), .alu_instr_mask(alu_instr_mask), .alu_vs1_index(alu_vs1_index),
        .alu_vsew(alu_vsew), .alu_op_type(alu_op_type), .alu_vl(alu_vl),
        .alu_arith_remaining(alu_arith_remaining), .alu_run(alu_run), .alu_done(alu_done),
        .alu_instr_valid(alu_instr_valid), .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready),
        .cmpl_illegal(cmpl_illegal), .cmpl_timeout(cmpl_timeout), .cmpl_opcode(cmpl_opcode),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // issued instruction stream and the wrapper behaviour attached to each entry
    logic [5:0]  a_op   [N];
    logic        a_mask [N];
    logic [4:0]  a_vs1  [N];
    logic [2:0]  a_vsew [N];
    logic [2:0]  a_opt  [N];
    logic [16:0] a_vl   [N];
    bit          a_iv   [N];
    int          a_dl   [N];

    int nissued = 0, ncmpl = 0, run_cnt = 0, rdy_mode = 2;
    int first_run_cyc = 0, last_run_cyc = 0, cv_cyc = 0, acc_cyc = 0;
    bit seen_cv = 0, mon_en = 0;
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // outcome of instruction k from the sequencing rules alone
    function automatic void expect_of(input int k, output int runs, output bit ill, output bit to);
        ill = 1'b0;
        to  = 1'b0;
        if (a_vl[k] == '0) runs = 0;
        else if (!a_iv[k]) begin
            runs = 1;
            ill  = 1'b1;
        end
`ifdef RVV_ALU_SEQ_WATCHDOG_EN
        else if (a_dl[k] > TO) begin
            runs = TO;
            to   = 1'b1;
        end
`endif
        else runs = a_dl[k];
    endfunction

    // wrapper model and completion checker, acting between clock edges
    always @(negedge clk) begin
        int cur, er, vli, rem;
        bit ei, et, rdy;
        if (!mon_en) begin
            alu_done        = 1'b0;
            cmpl_ready      = 1'b0;
            alu_instr_valid = 1'b1;
        end else begin
            cur = ncmpl;
            alu_instr_valid = a_iv[cur];
            if (alu_run) begin
                if (run_cnt == 0) begin
                    first_run_cyc = int'(cyc);
                    vli = int'(a_vl[cur]);
                    rem = (vli < LANES) ? vli : LANES;
                    chk("cfg_opcode", 32'(alu_opcode), 32'(a_op[cur]));
                    chk("cfg_mask", 32'(alu_instr_mask), 32'(a_mask[cur]));
                    chk("cfg_vs1", 32'(alu_vs1_index), 32'(a_vs1[cur]));
                    chk("cfg_vsew", 32'(alu_vsew), 32'(a_vsew[cur]));
                    chk("cfg_op_type", 32'(alu_op_type), 32'(a_opt[cur]));
                    chk("cfg_vl", 32'(alu_vl), 32'(a_vl[cur]));
                    chk("cfg_remaining", 32'(alu_arith_remaining), rem);
                end
                run_cnt++;
                last_run_cyc = int'(cyc);
                alu_done = (run_cnt == a_dl[cur]);
            end else begin
                alu_done = 1'b0;
            end
            if (cmpl_valid) begin
                if (!seen_cv) begin
                    seen_cv = 1'b1;
                    cv_cyc  = int'(cyc);
                end
                rdy = (rdy_mode == 2) ? 1'b1 : (rdy_mode == 1) ? ($urandom % 3 != 0) : 1'b0;
                cmpl_ready = rdy;
                if (rdy) begin
                    expect_of(cur, er, ei, et);
                    chk("cmpl_opcode", 32'(cmpl_opcode), 32'(a_op[cur]));
                    chk("cmpl_illegal", 32'(cmpl_illegal), 32'(ei));
                    chk("cmpl_timeout", 32'(cmpl_timeout), 32'(et));
                    chk("run_cycles", run_cnt, er);
                    chk("run_low_in_resp", 32'(alu_run), 0);
                    chk("cfg_held_vl", 32'(alu_vl), 32'(a_vl[cur]));
                    if (er > 0) chk("done_to_cmpl", cv_cyc - last_run_cyc, 1);
                    ncmpl++;
                    run_cnt = 0;
                    seen_cv = 1'b0;
                end
            end else begin
                cmpl_ready = 1'b0;
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [16:0] vl, input bit iv, input int dl);
        int k;
        k = nissued;
        a_op[k] = op;  a_vl[k] = vl;  a_iv[k] = iv;  a_dl[k] = dl;
        a_mask[k] = 1'($urandom);  a_vs1[k] = 5'($urandom);
        a_vsew[k] = 3'($urandom);  a_opt[k] = 3'($urandom);
        @(negedge clk); #1;
        issue_opcode = op;  issue_vl = vl;  issue_mask = a_mask[k];
        issue_vs1_index = a_vs1[k];  issue_vsew = a_vsew[k];  issue_op_type = a_opt[k];
        issue_valid = 1'b1;
        for (int b = 0; b < 400; b++) begin
            if (issue_ready) begin
                @(negedge clk);
                acc_cyc = int'(cyc);
                nissued++;
                issue_valid = 1'b0;
                return;
            end
            @(negedge clk); #1;
        end
        chk("issue_accept", 32'(issue_ready), 1);
        issue_valid = 1'b0;
    endtask

    task automatic wait_cmpl(input int n);
        for (int b = 0; b < 3000 && ncmpl < n; b++) @(negedge clk);
        chk("wait_cmpl", ncmpl, n);
    endtask

    task automatic wait_run();
        for (int b = 0; b < 50 && !alu_run; b++) @(negedge clk);
        chk("run_seen", 32'(alu_run), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_issue_ready", 32'(issue_ready), 1);
        chk("rst_alu_run", 32'(alu_run), 0);
        chk("rst_cmpl_valid", 32'(cmpl_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu_vl", 32'(alu_vl), 0);
        chk("rst_remaining", 32'(alu_arith_remaining), 0);
        resetn = 1'b1;
        mon_en = 1'b1;

        issue(6'h15, 17'd8, 1'b1, 4);
        wait_cmpl(1);
        chk("first_run_latency", first_run_cyc - acc_cyc, 2);
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        issue(6'h2a, 17'd8, 1'b0, 3);
        wait_cmpl(2);

        issue(6'h07, 17'd0, 1'b1, 3);
        wait_cmpl(3);
        chk("vl0_latency", cv_cyc - acc_cyc, 2);

        rdy_mode = 0;
        for (int i = 0; i < 3; i++) issue(6'(8 + i), 17'd5, 1'b1, 2);
        repeat (6) @(negedge clk);
        chk("bp_issue_ready", 32'(issue_ready), 0);
        chk("bp_busy", 32'(busy), 1);
        chk("bp_no_cmpl", ncmpl, 3);
        rdy_mode = 2;
        wait_cmpl(6);

        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom % 3) @(negedge clk);
            issue(6'($urandom), ($urandom % 2 == 0) ? 17'($urandom_range(0, 9)) : 17'($urandom),
                  ($urandom % 5 != 0), $urandom_range(1, 6));
        end
        wait_cmpl(nissued);

        rdy_mode = 2;
        issue(6'h33, 17'd20, 1'b1, 100000);
`ifdef RVV_ALU_SEQ_WATCHDOG_EN
        wait_cmpl(nissued);
        issue(6'h34, 17'd20, 1'b1, 100000);
        wait_run();
        repeat (5) @(negedge clk);
`else
        wait_run();
        repeat (40) @(negedge clk);
        chk("wd_off_run_hold", 32'(alu_run), 1);
        chk("wd_off_no_cmpl", 32'(cmpl_valid), 0);
`endif
        mon_en = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("arst_alu_run", 32'(alu_run), 0);
        chk("arst_issue_ready", 32'(issue_ready), 1);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cmpl_valid", 32'(cmpl_valid), 0);
        chk("arst_alu_opcode", 32'(alu_opcode), 0);
        chk("arst_alu_vl", 32'(alu_vl), 0);
        @(negedge clk);
        resetn  = 1'b1;
        ncmpl   = nissued;
        run_cnt = 0;
        seen_cv = 1'b0;
        mon_en  = 1'b1;
        issue(6'h3c, 17'd7, 1'b1, 3);
        wait_cmpl(nissued);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
